fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch path. It owns the program counter, fetches instructions through a request/acknowledge port to an instruction memory with variable wait states, and holds each fetched word until the decode/execute stage consumes it. It also handles branch/jump redirects, including discarding an in-flight fetch, and halts on a misaligned PC. It sits between the next-PC logic and the instruction memory, replacing the free-running per-cycle PC update.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- next_pc  in  32  sequential/branch target from next-PC logic, sampled on consume
- consume  in  1  downstream accepts `instr` this cycle (ignored unless `instr_valid`)
- redirect  in  1  taken branch/jump resolved late; overrides everything but reset
- redirect_pc  in  32  redirect target
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  fetch address (= `pc`)
- mem_ack  in  1  memory returns `mem_rdata` this cycle
- mem_rdata  in  32  fetched word
- pc  out  32  address of the instruction being fetched or held
- instr  out  32  registered instruction word
- instr_valid  out  1  `instr` holds a valid word for `pc`
- fault  out  1  sticky: misaligned PC detected
- retire_cnt  out  32  count of consumed instructions; wraps modulo 2^32

## Operation
- States: IDLE, FETCH, HOLD, DISCARD, HALT.
- Reset (`rst`=0, asynchronous) forces:
  - state=IDLE, pc=RESET_PC
  - instr=0, instr_valid=0, fault=0
  - retire_cnt=0, pend_pc=0
  - mem_req=0
- IDLE:
  - Without redirect, go to FETCH next cycle.
  - With redirect, load pc=redirect_pc first.
- FETCH:
  - mem_req=1 and mem_addr=pc; both stay stable until mem_ack.
  - On mem_ack without redirect: instr<=mem_rdata, instr_valid<=1, go to HOLD.
- HOLD:
  - mem_req=0 and instr stays stable.
  - On consume without redirect: retire_cnt+1, pc<=next_pc, instr_valid<=0, go to FETCH.
- Redirect:
  - FETCH with mem_ack in the same cycle: drop mem_rdata, pc<=redirect_pc, stay in FETCH.
  - FETCH without mem_ack: pend_pc<=redirect_pc, go to DISCARD. The request is never withdrawn.
  - HOLD: instr_valid<=0, pc<=redirect_pc, go to FETCH; no retire, even if consume is high.
  - DISCARD: pend_pc<=redirect_pc (last redirect wins).
- DISCARD:
  - mem_req=1 with the old address.
  - On mem_ack: drop the data, pc<=pend_pc, go to FETCH.
- Alignment check:
  - Every value loaded into pc (next_pc, redirect_pc, pend_pc) is checked.
  - If bits [1:0]≠0: go to HALT, fault<=1, pc takes the bad value, mem_req is never raised for it.
- HALT:
  - Absorbing; only reset leaves it.
  - instr_valid=0, mem_req=0.
- Width rules:
  - pc is used as given; no wrap handling beyond natural 32-bit overflow.
  - retire_cnt wraps from 32'hFFFF_FFFF to 0.

## Timing
- mem_req and mem_addr are decoded from registered state and pc; there is no combinational path from inputs to mem_req.
- A zero-wait-state memory (mem_ack in the same cycle as mem_req) gives:
  - instr_valid in the cycle after ack
  - 2 cycles per instruction when consume is held high.
- Each wait state adds one cycle.
- pc changes only at a clock edge: on consume, on redirect, or on the DISCARD ack.
- After reset deassertion: IDLE for 1 cycle, then mem_req is high in cycle 2.
- Reset asserted mid-fetch: mem_req drops immediately (asynchronous). Any later mem_ack for that fetch is ignored because the state is IDLE.

## Structure
- Shared header `fetch_defs.vh`: state encodings, RESET_PC default, instruction/address widths.
- Single module with the FSM inline.
- Optional sub-module `pc_reg`: a 32-bit register with async active-low reset and load enable, plus the alignment check output.

## Test plan
- Reset release, zero-wait memory, consume tied to 1 → mem_addr sequence 0x0, 0x4, 0x8; instr_valid every other cycle; retire_cnt=3 after 6 cycles.
- Memory with 3 wait states on the fetch at 0x4 → mem_req and mem_addr=0x4 held for 4 cycles; instr equals mem_rdata at ack; no retire during the wait.
- Redirect to 0x40 during the 2nd wait cycle of the fetch at 0x8 → DISCARD; ack data not seen on instr; next mem_addr=0x40; retire_cnt unchanged.
- Redirect and consume in the same HOLD cycle, redirect_pc=0x100 → pc=0x100, no retire, instr_valid=0 for the next cycle.
- next_pc=0x102 on consume → fault=1, HALT, mem_req stays 0 for 20 cycles. Reset then restores pc=RESET_PC and fault=0.
- Preload retire_cnt near 32'hFFFF_FFFF via 2^32−1 consumes (or force) → it wraps to 0 on the next consume.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller: datapath width,
// reset PC, FSM state encoding and the PC alignment predicate.
package fetch_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // Instructions are word aligned; any set low bit is a fault.
  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// fetch_ctrl_pc_reg
// Program-counter register with load enable.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (q <= RESET_PC)
//   load         load d into q at the next edge
//   d            candidate PC value
//   q            current PC
//   d_misaligned d is not word aligned (combinational on d)
module fetch_ctrl_pc_reg
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q,
  output logic            d_misaligned
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

  assign d_misaligned = misaligned(d);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencer. Owns the PC, issues one request at a time to
// an instruction memory with arbitrary wait states, holds the fetched word
// until downstream consumes it, handles late redirects (including dropping
// an in-flight fetch) and halts permanently on a misaligned PC.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   next_pc               sequential/branch target, loaded on consume
//   consume               downstream takes instr this cycle
//   redirect, redirect_pc late branch/jump redirect and its target
//   mem_req, mem_addr     memory request / address (address = pc)
//   mem_ack, mem_rdata    memory response / data
//   pc                    address of the instruction fetched or held
//   instr, instr_valid    held instruction word and its valid flag
//   fault                 sticky misaligned-PC flag
//   retire_cnt            number of consumed instructions (wraps)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc,
  input  logic            consume,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            fault,
  output logic [XLEN-1:0] retire_cnt
);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
  logic [XLEN-1:0] instr_reg, instr_next;
  logic            valid_reg, valid_next;
  logic            fault_reg, fault_next;
  logic [XLEN-1:0] retire_cnt_reg, retire_cnt_next;

  logic            pc_load;
  logic [XLEN-1:0] pc_d;
  logic            pc_d_bad;

  fetch_ctrl_pc_reg u_pc (
    .clk          (clk),
    .rst          (rst),
    .load         (pc_load),
    .d            (pc_d),
    .q            (pc),
    .d_misaligned (pc_d_bad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      pend_pc_reg    <= '0;
      instr_reg      <= '0;
      valid_reg      <= 1'b0;
      fault_reg      <= 1'b0;
      retire_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      pend_pc_reg    <= pend_pc_next;
      instr_reg      <= instr_next;
      valid_reg      <= valid_next;
      fault_reg      <= fault_next;
      retire_cnt_reg <= retire_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pend_pc_next    = pend_pc_reg;
    instr_next      = instr_reg;
    valid_next      = valid_reg;
    fault_next      = fault_reg;
    retire_cnt_next = retire_cnt_reg;
    pc_load         = 1'b0;
    pc_d            = redirect_pc;

    case (state_reg)
      ST_IDLE: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = redirect_pc;
        end
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect) begin
          if (mem_ack) begin
            // Response for the old PC arrives with the redirect: drop it
            // and refetch at the new target straight away.
            pc_load = 1'b1;
            pc_d    = redirect_pc;
          end else begin
            // Request cannot be withdrawn; park the target until the
            // outstanding response is drained.
            pend_pc_next = redirect_pc;
            state_next   = ST_DISCARD;
          end
        end else if (mem_ack) begin
          instr_next = mem_rdata;
          valid_next = 1'b1;
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          // Redirect wins over a simultaneous consume: nothing retires.
          valid_next = 1'b0;
          pc_load    = 1'b1;
          pc_d       = redirect_pc;
          state_next = ST_FETCH;
        end else if (consume && valid_reg) begin
          retire_cnt_next = retire_cnt_reg + 1'b1;
          valid_next      = 1'b0;
          pc_load         = 1'b1;
          pc_d            = next_pc;
          state_next      = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        if (redirect) begin
          if (mem_ack) begin
            pc_load    = 1'b1;
            pc_d       = redirect_pc;
            state_next = ST_FETCH;
          end else begin
            pend_pc_next = redirect_pc;
          end
        end else if (mem_ack) begin
          pc_load    = 1'b1;
          pc_d       = pend_pc_reg;
          state_next = ST_FETCH;
        end
      end

      ST_HALT: begin
        valid_next = 1'b0;
      end

      default: begin
        state_next = ST_HALT;
        valid_next = 1'b0;
      end
    endcase

    // A misaligned PC is still loaded (for visibility) but the FSM parks in
    // HALT so no request is ever issued for it.
    if (pc_load && pc_d_bad) begin
      state_next = ST_HALT;
      fault_next = 1'b1;
      valid_next = 1'b0;
    end
  end

  // Request is purely a decode of registered state.
  assign mem_req     = (state_reg == ST_FETCH) || (state_reg == ST_DISCARD);
  assign mem_addr    = pc;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign fault       = fault_reg;
  assign retire_cnt  = retire_cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Scoreboard bench for fetch_ctrl. Stimulus pushes the expected fetch
// addresses and expected {pc, instr} pairs; a monitor pops and compares each
// time the DUT starts a new request or presents a new instruction. Directed
// point checks cover reset, wait states, redirects, halt and counter wrap.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc;
  logic        consume = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;
  logic [31:0] retire_cnt;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];

  // Next-PC logic stand-in: sequential unless overridden.
  logic        np_ovr_en = 1'b0;
  logic [31:0] np_ovr = 32'h0;
  assign next_pc = np_ovr_en ? np_ovr : pc + 32'd4;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .consume     (consume),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault),
    .retire_cnt  (retire_cnt)
  );

  // Instruction memory: word = 0xC0DE_0000 ^ addr, slow_waits wait states
  // for slow_addr, zero elsewhere.
  logic [31:0] slow_addr = 32'hFFFF_FFF0;
  int          slow_waits = 0;
  int          wcnt = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= ((mem_addr == slow_addr) ? slow_waits : 0)) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hC0DE_0000 ^ mem_addr;
        wcnt      = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        wcnt      = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: one line per observed transaction.
  logic        prev_valid = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  initial begin
    forever begin
      logic [63:0] e;
      @(negedge clk);
      #1;
      if (rst) begin
        if (mem_req && (!prev_req || mem_addr != prev_addr)) begin
          $display("[%0t] fetch request addr=%h", $time, mem_addr);
          if (exp_addr_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL fetch_addr: unexpected request at %h, none expected", mem_addr);
          end else begin
            chk32("fetch_addr", mem_addr, exp_addr_q.pop_front());
          end
        end
        if (instr_valid && !prev_valid) begin
          $display("[%0t] instr presented pc=%h instr=%h", $time, pc, instr);
          if (exp_instr_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL instr: unexpected instruction pc=%h instr=%h", pc, instr);
          end else begin
            e = exp_instr_q.pop_front();
            chk32("instr_pc", pc, e[63:32]);
            chk32("instr_word", instr, e[31:0]);
          end
        end
      end
      prev_valid = instr_valid;
      prev_req   = mem_req;
      prev_addr  = mem_addr;
    end
  end

  // Asserts reset on a negedge, checks asynchronous drop and reset state,
  // then releases on a later negedge (N0); the FSM is in IDLE afterwards.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    consume     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    np_ovr_en   = 1'b0;
    #1;
    chk1("rst_async_mem_req", mem_req, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk32("rst_pc", pc, 32'h0);
    chk32("rst_instr", instr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk32("rst_retire", retire_cnt, 32'h0);
    rst = 1'b1;
    chk1("idle_no_req", mem_req, 1'b0);
  endtask

  initial begin
    int req_hi;

    // A: zero-wait memory, consume held high.
    slow_waits = 0;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    exp_instr_q.push_back({32'h0, 32'hC0DE_0000});
    exp_instr_q.push_back({32'h4, 32'hC0DE_0004});
    exp_instr_q.push_back({32'h8, 32'hC0DE_0008});
    exp_instr_q.push_back({32'hC, 32'hC0DE_000C});
    consume = 1'b1;
    tick();
    chk1("a_req_cycle2", mem_req, 1'b1);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk1("a_valid_alternate", instr_valid, (k % 2) == 0);
    end
    chk32("a_retire_after_6", retire_cnt, 32'd3);
    consume = 1'b0;
    tick();
    tick();

    // B: three wait states on the fetch at 0x4.
    slow_addr  = 32'h4;
    slow_waits = 3;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_instr_q.push_back({32'h0, 32'hC0DE_0000});
    exp_instr_q.push_back({32'h4, 32'hC0DE_0004});
    consume = 1'b1;
    tick();
    tick();
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk1("b_wait_req", mem_req, 1'b1);
      chk32("b_wait_addr", mem_addr, 32'h4);
      chk32("b_wait_retire", retire_cnt, 32'd1);
      chk1("b_wait_valid", instr_valid, 1'b0);
    end
    tick();
    chk1("b_req_dropped", mem_req, 1'b0);
    chk1("b_valid", instr_valid, 1'b1);
    chk32("b_instr", instr, 32'hC0DE_0004);
    consume = 1'b0;
    tick();

    // C: redirect to 0x40 in the 2nd wait cycle of the fetch at 0x8.
    slow_addr  = 32'h8;
    slow_waits = 3;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'h40);
    exp_instr_q.push_back({32'h0, 32'hC0DE_0000});
    exp_instr_q.push_back({32'h4, 32'hC0DE_0004});
    exp_instr_q.push_back({32'h40, 32'hC0DE_0040});
    consume = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    chk32("c_fetch8_addr", mem_addr, 32'h8);
    chk32("c_retire_before", retire_cnt, 32'd2);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk1("c_discard_req", mem_req, 1'b1);
    chk32("c_discard_addr", mem_addr, 32'h8);
    chk1("c_discard_valid", instr_valid, 1'b0);
    tick();
    chk32("c_pc_held", pc, 32'h8);
    tick();
    consume = 1'b0;
    chk32("c_refetch_addr", mem_addr, 32'h40);
    chk32("c_retire_kept", retire_cnt, 32'd2);
    tick();
    chk1("c_valid", instr_valid, 1'b1);
    chk32("c_instr", instr, 32'hC0DE_0040);
    chk32("c_retire_final", retire_cnt, 32'd2);
    tick();

    // D: redirect and consume together in HOLD.
    slow_waits = 0;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h100);
    exp_instr_q.push_back({32'h0, 32'hC0DE_0000});
    exp_instr_q.push_back({32'h100, 32'hC0DE_0100});
    tick();
    tick();
    consume     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    consume  = 1'b0;
    redirect = 1'b0;
    chk32("d_pc", pc, 32'h100);
    chk32("d_no_retire", retire_cnt, 32'd0);
    chk1("d_valid_low", instr_valid, 1'b0);
    tick();
    chk1("d_valid_again", instr_valid, 1'b1);
    chk32("d_retire_still0", retire_cnt, 32'd0);
    tick();

    // E: misaligned next_pc on consume -> HALT, then reset recovers.
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_instr_q.push_back({32'h0, 32'hC0DE_0000});
    tick();
    tick();
    np_ovr_en = 1'b1;
    np_ovr    = 32'h102;
    consume   = 1'b1;
    tick();
    consume = 1'b0;
    chk1("e_fault", fault, 1'b1);
    chk32("e_pc_bad", pc, 32'h102);
    chk1("e_valid", instr_valid, 1'b0);
    chk32("e_retire", retire_cnt, 32'd1);
    req_hi = 0;
    for (int k = 0; k < 20; k++) begin
      redirect    = (k == 5);
      redirect_pc = 32'h200;
      consume     = (k == 10);
      tick();
      if (mem_req) req_hi++;
    end
    redirect = 1'b0;
    consume  = 1'b0;
    chk32("e_halt_req_cycles", req_hi, 32'd0);
    chk32("e_halt_pc", pc, 32'h102);
    chk1("e_fault_sticky", fault, 1'b1);
    do_reset();

    // F: retire counter wrap.
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_instr_q.push_back({32'h0, 32'hC0DE_0000});
    exp_instr_q.push_back({32'h4, 32'hC0DE_0004});
    tick();
    force dut.retire_cnt_reg = 32'hFFFF_FFFF;
    tick();
    release dut.retire_cnt_reg;
    chk32("f_preload", retire_cnt, 32'hFFFF_FFFF);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk32("f_wrap", retire_cnt, 32'h0);
    tick();
    chk1("f_valid", instr_valid, 1'b1);
    tick();
    tick();

    chk32("pending_fetch_expectations", exp_addr_q.size(), 32'd0);
    chk32("pending_instr_expectations", exp_instr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
